// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, WIDTH iterations per op.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 a_neg_q, a_neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic                 accept_s, muldiv_s, signed_s, last_s, is_div_s;
  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [WIDTH:0]       add_s, trial_s;
  logic [2*WIDTH-1:0]   step_s, prod_s;
  logic [WIDTH-1:0]     quot_s, rem_s;

  assign accept_s = start_i && !flush_i && (state_q != S_RUN);
  assign muldiv_s = (op_i[2:1] != 2'b11);
  assign signed_s = (op_i == OP_MULT) || (op_i == OP_DIV) || (op_i == OP_MADD) || (op_i == OP_MSUB);
  assign last_s   = (state_q == S_RUN) && (cnt_q == {CW{1'b0}}) && !flush_i;
  assign is_div_s = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign a_mag_s  = (signed_s && operand_a_i[WIDTH-1]) ? neg_w(operand_a_i) : operand_a_i;
  assign b_mag_s  = (signed_s && operand_b_i[WIDTH-1]) ? neg_w(operand_b_i) : operand_b_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush always wins over a same-cycle start
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (accept_s && muldiv_s) ? S_RUN : S_IDLE;
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == {CW{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = (accept_s && muldiv_s) ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One iteration: multiply adds the multiplicand then shifts right; divide shifts left and trial-subtracts
  always_comb begin
    add_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    trial_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mcand_q};
    if (is_div_s) begin
      if (!trial_s[WIDTH]) begin
        step_s = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step_s = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      step_s = {add_s, acc_q[WIDTH-1:1]};
    end
    prod_s = neg_q ? neg_2w(step_s) : step_s;
    quot_s = neg_q ? neg_w(step_s[WIDTH-1:0]) : step_s[WIDTH-1:0];
    rem_s  = a_neg_q ? neg_w(step_s[2*WIDTH-1:WIDTH]) : step_s[2*WIDTH-1:WIDTH];
  end

  // Operand capture on accept, iteration while running
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    a_neg_d = a_neg_q;
    if (accept_s && muldiv_s) begin
      op_d    = op_i;
      a_d     = operand_a_i;
      neg_d   = signed_s && (operand_a_i[WIDTH-1] ^ operand_b_i[WIDTH-1]);
      a_neg_d = signed_s && operand_a_i[WIDTH-1];
      cnt_d   = CW'(WIDTH - 1);
      if (op_i[2:1] == 2'b01) begin
        mcand_d = b_mag_s;
        acc_d   = {{WIDTH{1'b0}}, a_mag_s};
      end else begin
        mcand_d = a_mag_s;
        acc_d   = {{WIDTH{1'b0}}, b_mag_s};
      end
    end else if (state_q == S_RUN) begin
      acc_d = step_s;
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      acc_d = acc_q;
    end
  end

  // Output next-state: MTHI/MTLO write immediately, mul/div results land on the final iteration edge
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    dbz_d  = dbz_q;
    busy_d = (state_d == S_RUN);
    if (accept_s && (op_i == OP_MTHI)) begin
      hi_d = operand_a_i;
    end else if (accept_s && (op_i == OP_MTLO)) begin
      lo_d = operand_a_i;
    end else if (last_s) begin
      done_d = 1'b1;
      dbz_d  = 1'b0;
      case (op_q)
        OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_s;
        OP_MADD:           {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
        OP_MSUB:           {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
        OP_DIV, OP_DIVU: begin
          if (mcand_q == {WIDTH{1'b0}}) begin
            hi_d  = a_q;
            lo_d  = {WIDTH{1'b1}};
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_s;
            lo_d = quot_s;
          end
        end
        default: {hi_d, lo_d} = {hi_q, lo_q};
      endcase
    end else begin
      done_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= 3'b000;
      a_q     <= {WIDTH{1'b0}};
      mcand_q <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      cnt_q   <= {CW{1'b0}};
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      a_neg_q <= a_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: a vector table run back to back, plus flush/back-to-back/reset sequences.
module tb_muldiv_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a_in, b_in;
  logic         flush;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  vec_t vecs[17];

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op),
    .operand_a_i(a_in), .operand_b_i(b_in), .flush_i(flush),
    .busy_o(busy), .done_o(done), .div_by_zero_o(dbz), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present an op for one accepting edge, then scramble operands to prove they were latched.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0; a_in = $urandom; b_in = $urandom; op = 3'($urandom_range(0, 5));
  endtask

  // Waits up to 40 edges for done; returns the edge count (0 on timeout) and whether busy held until then.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = busy;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic no_done_window(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check(name, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    int lat;
    bit bok;
    logic [W-1:0] hold_hi, hold_lo;

    vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{3'b011, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{3'b001, 32'h00000003, 32'h00000003, 32'h00000000, 32'h00000009, 1'b0};
    vecs[7]  = '{3'b110, 32'h00000005, 32'h00000000, 32'h00000005, 32'h00000009, 1'b0};
    vecs[8]  = '{3'b111, 32'h00000007, 32'h00000000, 32'h00000005, 32'h00000007, 1'b0};
    vecs[9]  = '{3'b100, 32'h00000002, 32'h00000003, 32'h00000005, 32'h0000000D, 1'b0};
    vecs[10] = '{3'b101, 32'h00000001, 32'h0000000E, 32'h00000004, 32'hFFFFFFFF, 1'b0};
    vecs[11] = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[12] = '{3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[13] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[14] = '{3'b101, 32'hFFFFFFFD, 32'h00000005, 32'h40000000, 32'h0000000F, 1'b0};
    vecs[15] = '{3'b010, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[16] = '{3'b110, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};

    rst_n = 1'b0; start = 1'b0; op = 3'b000; a_in = '0; b_in = '0; flush = 1'b0;
    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_dbz", {63'd0, dbz}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 17; v++) begin
      issue(vecs[v].op, vecs[v].a, vecs[v].b);
      if (vecs[v].op[2:1] == 2'b11) begin
        check($sformatf("v%0d_mt_busy", v), {62'd0, busy, done}, 64'd0);
      end else begin
        wait_done(lat, bok);
        check($sformatf("v%0d_latency", v), 64'(lat), 64'd32);
        check($sformatf("v%0d_busy_held", v), {63'd0, bok}, 64'd1);
        check($sformatf("v%0d_busy_at_done", v), {63'd0, busy}, 64'd0);
      end
      check($sformatf("v%0d_hi", v), {32'd0, hi}, {32'd0, vecs[v].hi});
      check($sformatf("v%0d_lo", v), {32'd0, lo}, {32'd0, vecs[v].lo});
      check($sformatf("v%0d_dbz", v), {63'd0, dbz}, {63'd0, vecs[v].dbz});
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", v), {63'd0, done}, 64'd0);
    end

    // Flush on the 5th RUN cycle; an MTHI issued mid-run must be ignored
    hold_hi = vecs[16].hi;
    hold_lo = vecs[16].lo;
    issue(3'b001, 32'd6, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; op = 3'b110; a_in = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_after", {63'd0, busy}, 64'd0);
    no_done_window("flush_no_done");
    check("flush_hilo_kept", {hi, lo}, {hold_hi, hold_lo});

    // Back-to-back: second op accepted in the DONE cycle of the first
    issue(3'b001, 32'd2, 32'd3);
    wait_done(lat, bok);
    check("b2b_first_latency", 64'(lat), 64'd32);
    check("b2b_first_lo", {32'd0, lo}, 64'd6);
    start = 1'b1; op = 3'b001; a_in = 32'd4; b_in = 32'd5;
    lat = 0;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      if (j == 1) start = 1'b0;
      if (done) begin
        lat = j;
        break;
      end
    end
    check("b2b_gap", 64'(lat), 64'd33);
    check("b2b_second_hilo", {hi, lo}, 64'd20);

    // Start+Flush in DONE: start dropped, completed result kept
    @(posedge clk); #1;
    issue(3'b001, 32'd5, 32'd5);
    wait_done(lat, bok);
    check("dflush_latency", 64'(lat), 64'd32);
    start = 1'b1; flush = 1'b1; op = 3'b001; a_in = 32'd9; b_in = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("dflush_hilo", {hi, lo}, 64'h19);
    no_done_window("dflush_no_run");
    check("dflush_hilo_after", {hi, lo}, 64'h19);

    // Reset asserted mid-run clears everything asynchronously
    issue(3'b001, 32'd3, 32'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_done_dbz", {62'd0, done, dbz}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    no_done_window("rst_no_done");
    check("rst_hilo_after", {hi, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
